midi_tx: RTL and testbench

MIDI serial transmitter: the sending end of the 31250-baud MIDI link that the `midi` keyboard receiver decodes on `JA[0]`. It accepts note events over a valid/ready handshake and frames them as Note On / Note Off messages. Each message is a status byte, a key byte and a velocity byte, sent as 8N1 UART frames. It sits in the 65 MHz domain. Its output drives a Pmod pin for loopback testing of the receiver or for driving an external synth.

---
 rtl/midi_tx.sv | 117 +++++++++++
 tb/tb_midi_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI 8N1 Note On/Off transmitter; MIDI_TX_RUNNING_STATUS_EN enables running status
module midi_tx #(
    parameter int         CLKS_PER_BIT = 2080,
    parameter logic [3:0] CHANNEL      = 4'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic       note_on,
    input  logic [6:0] key_index,
    input  logic [6:0] velocity,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       serial
);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [TW-1:0] bit_timer;
    logic [2:0]    bit_count;
    logic [1:0]    byte_index;
    logic [1:0]    first_index;
    logic [7:0]    status_byte, key_byte, vel_byte;
    logic [7:0]    new_status, cur_byte;
    logic          accept, bit_end, last_byte;

    assign new_status = {3'b100, note_on, CHANNEL};
    assign accept     = send & ready;
    assign bit_end    = (bit_timer == TIMER_LAST);
    assign last_byte  = (byte_index == 2'd2);

`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] last_status;

    // The status register is loaded at acceptance; when skipped it already holds the same value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            last_status <= 8'h00;
        else if (accept)
            last_status <= new_status;
    end

    assign first_index = (new_status == last_status) ? 2'd1 : 2'd0;
`else
    assign first_index = 2'd0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && bit_count == 3'd7) state_next = STOP;
            STOP:  if (bit_end) state_next = last_byte ? IDLE : START;
        endcase
    end

    always_comb begin
        ready  = (state == IDLE);
        busy   = ~ready;
        serial = 1'b1;
        case (state)
            START:   serial = 1'b0;
            DATA:    serial = cur_byte[bit_count];
            default: serial = 1'b1;
        endcase
    end

    always_comb begin
        case (byte_index)
            2'd0:    cur_byte = status_byte;
            2'd1:    cur_byte = key_byte;
            default: cur_byte = vel_byte;
        endcase
    end

    // Timer restarts at every bit boundary, which is also every state entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_timer   <= '0;
            bit_count   <= 3'd0;
            byte_index  <= 2'd0;
            done        <= 1'b0;
            status_byte <= 8'h00;
            key_byte    <= 8'h00;
            vel_byte    <= 8'h00;
        end else begin
            done <= (state == STOP) && bit_end && last_byte;
            if (state == IDLE || bit_end)
                bit_timer <= '0;
            else
                bit_timer <= bit_timer + TIMER_ONE;
            if (state == DATA && bit_end)
                bit_count <= bit_count + 3'd1;
            if (accept) begin
                byte_index  <= first_index;
                status_byte <= new_status;
                key_byte    <= {1'b0, key_index};
                vel_byte    <= {1'b0, velocity};
            end else if (state == STOP && bit_end && !last_byte) begin
                byte_index <= byte_index + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - scoreboard bench for midi_tx at CLKS_PER_BIT=16, channels 0 and 3
module tb_midi_tx;
    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic       note_on = 1'b0;
    logic [6:0] key_index = 7'd0;
    logic [6:0] velocity = 7'd0;
    logic       ready, busy, done, serial;
    logic       ready3, busy3, done3, serial3;

    int n_checks = 0;
    int n_pass = 0;
    int inv_err = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tb_last = 8'h00;

    midi_tx #(.CLKS_PER_BIT(CPB), .CHANNEL(4'd0)) u_dut (
        .clock(clock), .reset(reset), .send(send), .note_on(note_on),
        .key_index(key_index), .velocity(velocity),
        .ready(ready), .busy(busy), .done(done), .serial(serial)
    );

    midi_tx #(.CLKS_PER_BIT(CPB), .CHANNEL(4'd3)) u_dut_ch3 (
        .clock(clock), .reset(reset), .send(send), .note_on(note_on),
        .key_index(key_index), .velocity(velocity),
        .ready(ready3), .busy(busy3), .done(done3), .serial(serial3)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Line decoder: mid-bit sampling of both transmitters against the expected byte queue.
    initial begin
        int         cnt;
        bit         active;
        logic [7:0] sh, sh3, e;
        active = 1'b0;
        cnt = 0;
        sh = 8'h00;
        sh3 = 8'h00;
        forever begin
            @(negedge clock);
            if (busy === ready || busy3 === ready3) inv_err++;
            if (done === 1'b1) done_cnt++;
            if (reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (serial == 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt == CPB / 2) begin
                    check("start_bit", int'(serial), 0);
                    check("start_bit_ch3", int'(serial3), 0);
                end
                if (cnt >= CPB + CPB / 2 && cnt < 9 * CPB && (cnt - CPB / 2) % CPB == 0) begin
                    sh[(cnt - CPB - CPB / 2) / CPB] = serial;
                    sh3[(cnt - CPB - CPB / 2) / CPB] = serial3;
                end
                if (cnt == 9 * CPB + CPB / 2) begin
                    check("stop_bit", int'(serial), 1);
                    check("stop_bit_ch3", int'(serial3), 1);
                    if (exp_q.size() == 0) begin
                        check("sb_extra_byte", int'(sh), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", int'(sh), int'(e));
                        check("byte_ch3", int'(sh3), int'(e[7] ? (e | 8'h03) : e));
                    end
                    active = 1'b0;
                end
            end
        end
    end

    function automatic int push_msg(input bit on, input logic [6:0] k, input logic [6:0] v);
        logic [7:0] st;
        int nb;
        st = on ? 8'h90 : 8'h80;
        nb = 2;
`ifdef MIDI_TX_RUNNING_STATUS_EN
        if (st != tb_last) begin
            exp_q.push_back(st);
            nb = 3;
        end
`else
        exp_q.push_back(st);
        nb = 3;
`endif
        tb_last = st;
        exp_q.push_back({1'b0, k});
        exp_q.push_back({1'b0, v});
        return nb;
    endfunction

    task automatic run_msg(input bit on, input logic [6:0] k, input logic [6:0] v,
                           input int ignore_at, input int reset_at);
        int nb;
        int n;
        bit finished;
        check("ready_idle", int'(ready), 1);
        nb = push_msg(on, k, v);
        @(negedge clock);
        send = 1'b1;
        note_on = on;
        key_index = k;
        velocity = v;
        @(posedge clock);
        #1;
        send = 1'b0;
        check("ready_low_after_accept", int'(ready), 0);
        check("start_latency", int'(serial), 0);
        finished = 1'b0;
        for (n = 1; n <= 40 * CPB && !finished; n++) begin
            @(posedge clock);
            #1;
            send = 1'b0;
            if (n == ignore_at) begin
                send = 1'b1;
                note_on = 1'b0;
                key_index = 7'd5;
                velocity = 7'd5;
            end
            if (n == reset_at) begin
                #2;
                check("pre_reset_low", int'(serial), 0);
                reset = 1'b1;
                #1;
                check("async_reset_serial", int'(serial), 1);
                check("async_reset_ready", int'(ready), 1);
                check("async_reset_busy", int'(busy), 0);
                check("async_reset_done", int'(done), 0);
                repeat (3) @(posedge clock);
                exp_q.delete();
                tb_last = 8'h00;
                @(negedge clock);
                reset = 1'b0;
                finished = 1'b1;
            end else if (done === 1'b1) begin
                check("done_latency", n, 10 * CPB * nb);
                check("ready_with_done", int'(ready), 1);
                check("busy_with_done", int'(busy), 0);
                finished = 1'b1;
            end
        end
        if (!finished) check("done_timeout", 0, 1);
        @(negedge clock);
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_serial", int'(serial), 1);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_msg(1'b1, 7'd60, 7'd100, 0, 0);
        run_msg(1'b1, 7'd62, 7'd100, 0, 0);
        run_msg(1'b0, 7'd60, 7'd64, 0, 0);
        run_msg(1'b1, 7'd10, 7'd20, 100, 0);
        repeat (12 * CPB) @(negedge clock);
        check("sb_no_ghost", exp_q.size(), 0);
        run_msg(1'b0, 7'd127, 7'd0, 0, 0);
        run_msg(1'b1, 7'd60, 7'd100, 0, 200);
        run_msg(1'b1, 7'd64, 7'd90, 0, 0);
        repeat (4 * CPB) @(negedge clock);

        check("done_pulses", done_cnt, 6);
        check("busy_not_ready", inv_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
